clkdiv_multi: RTL

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

---
 rtl/clkdiv_multi.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CHANNELS independent programmable clock dividers with pulse/wave outputs
// and boundary-aligned reload. Define CLKDIV_MULTI_PHASE_EN to add the per-channel phase input.

module clkdiv_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS*CNT_WIDTH-1:0] divider,
    input  logic [CHANNELS*CNT_WIDTH-1:0] high_time,
    input  logic [CHANNELS-1:0]           load,
    input  logic                          sync,
`ifdef CLKDIV_MULTI_PHASE_EN
    input  logic [CHANNELS*CNT_WIDTH-1:0] phase,
`endif
    output logic [CHANNELS-1:0]           pulse,
    output logic [CHANNELS-1:0]           wave,
    output logic [CHANNELS-1:0]           pending
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic cnt_t eff_period(input cnt_t d);
        return (d == '0) ? cnt_t'(1) : d;
    endfunction

`ifdef CLKDIV_MULTI_PHASE_EN
    function automatic cnt_t clamp_start(input cnt_t p, input cnt_t d);
        cnt_t last;
        last = eff_period(d) - cnt_t'(1);
        return (p > last) ? last : p;
    endfunction
`endif

    // The first edge after reset release treats every channel as disabled.
    logic first_q;

    always_ff @(posedge clk) begin
        if (!reset_n) first_q <= 1'b1;
        else          first_q <= 1'b0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cnt_t cnt_q, act_d_q, act_h_q, stg_d_q, stg_h_q;
        logic pend_q, pulse_q, wave_q;
        cnt_t cnt_nxt, act_d_nxt, act_h_nxt, stg_d_nxt, stg_h_nxt;
        logic pend_nxt, pulse_nxt, wave_nxt;
        cnt_t div_in, hi_in, cur;
        logic run, wrap, commit;

        assign div_in = divider[i*CNT_WIDTH +: CNT_WIDTH];
        assign hi_in  = high_time[i*CNT_WIDTH +: CNT_WIDTH];
        assign run    = enable[i] & ~first_q;

`ifdef CLKDIV_MULTI_PHASE_EN
        cnt_t ph_in;
        logic en_q;
        assign ph_in = phase[i*CNT_WIDTH +: CNT_WIDTH];

        always_ff @(posedge clk) begin
            if (!reset_n) en_q <= 1'b0;
            else          en_q <= run;
        end
`endif

        always_comb begin
            cnt_nxt   = '0;
            act_d_nxt = act_d_q;
            act_h_nxt = act_h_q;
            stg_d_nxt = stg_d_q;
            stg_h_nxt = stg_h_q;
            pend_nxt  = 1'b0;
            pulse_nxt = 1'b0;
            wave_nxt  = 1'b0;
            cur       = cnt_q;
            wrap      = 1'b0;
            commit    = 1'b0;
            if (!run) begin
                act_d_nxt = div_in;
                act_h_nxt = hi_in;
            end else begin
`ifdef CLKDIV_MULTI_PHASE_EN
                // On the enabling edge the counter behaves as if it had been parked at the phase offset.
                if (!en_q) cur = clamp_start(ph_in, act_d_q);
`endif
                wrap   = (cur == eff_period(act_d_q) - cnt_t'(1));
                commit = wrap | sync;
                if (commit) begin
                    if (load[i]) begin
                        act_d_nxt = div_in;
                        act_h_nxt = hi_in;
                    end else if (pend_q) begin
                        act_d_nxt = stg_d_q;
                        act_h_nxt = stg_h_q;
                    end
                end else if (load[i]) begin
                    stg_d_nxt = div_in;
                    stg_h_nxt = hi_in;
                    pend_nxt  = 1'b1;
                end else begin
                    pend_nxt = pend_q;
                end
                if (sync) begin
`ifdef CLKDIV_MULTI_PHASE_EN
                    cnt_nxt = clamp_start(ph_in, act_d_nxt);
`else
                    cnt_nxt = '0;
`endif
                end else if (wrap) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cur + cnt_t'(1);
                end
                pulse_nxt = wrap & ~sync;
                wave_nxt  = (cnt_nxt < act_h_nxt);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt_q   <= '0;
                act_d_q <= '0;
                act_h_q <= '0;
                stg_d_q <= '0;
                stg_h_q <= '0;
                pend_q  <= 1'b0;
                pulse_q <= 1'b0;
                wave_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_nxt;
                act_d_q <= act_d_nxt;
                act_h_q <= act_h_nxt;
                stg_d_q <= stg_d_nxt;
                stg_h_q <= stg_h_nxt;
                pend_q  <= pend_nxt;
                pulse_q <= pulse_nxt;
                wave_q  <= wave_nxt;
            end
        end

        assign pulse[i]   = pulse_q;
        assign wave[i]    = wave_q;
        assign pending[i] = pend_q;
    end

endmodule
